// File: rtl/rv_ctl.sv
// Multicycle control unit for the simple RISC-V core: shared control encodings
// plus the FSM that sequences every datapath enable and mux select.

package rv_ctl_pkg;
  localparam logic       PC_PLUS4 = 1'b0;
  localparam logic       PC_ALU   = 1'b1;

  localparam logic [1:0] WB_MDR    = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] IMM_J = 2'd0;
  localparam logic [1:0] IMM_B = 2'd1;
  localparam logic [1:0] IMM_S = 2'd2;
  localparam logic [1:0] IMM_L = 2'd3;

  localparam logic       ALUA_REG = 1'b0;
  localparam logic       ALUA_PCC = 1'b1;
  localparam logic       ALUB_REG = 1'b0;
  localparam logic       ALUB_IMM = 1'b1;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
endpackage

module rv_ctl
  import rv_ctl_pkg::*;
#(
  parameter int DPWIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  instr,
  input  logic         zero,
  output logic         pcsourse,
  output logic         pcwrite,
  output logic         pccen,
  output logic         irwrite,
  output logic [1:0]   wbsel,
  output logic         regwen,
  output logic [1:0]   immsel,
  output logic         asel,
  output logic         bsel,
  output logic [3:0]   alusel,
  output logic         mdrwrite,
  output logic         memwrite,
  output logic         illegal
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    EXEC_R    = 4'd2,
    EXEC_I    = 4'd3,
    ALU_WB    = 4'd4,
    MEM_ADDR  = 4'd5,
    MEM_READ  = 4'd6,
    LOAD_WB   = 4'd7,
    MEM_WRITE = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    TRAP      = 4'd11
  } state_t;

  state_t state_reg, state_next;
  logic   illegal_reg;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign f7b    = instr[30];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  logic pcwrite_next, pccen_next, irwrite_next, regwen_next;
  logic mdrwrite_next, memwrite_next;

  // Only register-register ops may turn ADD into SUB; both forms honour SRA.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt,
                                            input logic reg_form);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (reg_form && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_reg | (state_next == TRAP);
    end
  end

  always_comb begin
    state_next    = state_reg;
    pcsourse      = PC_PLUS4;
    pcwrite_next  = 1'b0;
    pccen_next    = 1'b0;
    irwrite_next  = 1'b0;
    wbsel         = WB_ALUOUT;
    regwen_next   = 1'b0;
    immsel        = IMM_L;
    asel          = ALUA_REG;
    bsel          = ALUB_REG;
    alusel        = ALU_ADD;
    mdrwrite_next = 1'b0;
    memwrite_next = 1'b0;

    case (state_reg)
      FETCH: begin
        irwrite_next = 1'b1;
        pccen_next   = 1'b1;
        pcwrite_next = 1'b1;
        state_next   = DECODE;
      end
      DECODE: begin
        // Branch/jump target is formed here so BRANCH/JAL can load it from aluout.
        asel   = ALUA_PCC;
        bsel   = ALUB_IMM;
        immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
        if (opcode == OP_R)
          state_next = EXEC_R;
        else if (opcode == OP_I)
          state_next = EXEC_I;
        else if ((opcode == OP_LOAD || opcode == OP_STORE) && funct3 == F3_WORD)
          state_next = MEM_ADDR;
        else if (opcode == OP_BRANCH && (funct3 == F3_BEQ || funct3 == F3_BNE))
          state_next = BRANCH;
        else if (opcode == OP_JAL)
          state_next = JAL;
        else
          state_next = TRAP;
      end
      EXEC_R: begin
        alusel     = alu_decode(funct3, f7b, 1'b1);
        state_next = ALU_WB;
      end
      EXEC_I: begin
        bsel       = ALUB_IMM;
        alusel     = alu_decode(funct3, f7b, 1'b0);
        state_next = ALU_WB;
      end
      ALU_WB: begin
        regwen_next = 1'b1;
        state_next  = FETCH;
      end
      MEM_ADDR: begin
        bsel   = ALUB_IMM;
        immsel = (opcode == OP_STORE) ? IMM_S : IMM_L;
        state_next = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mdrwrite_next = 1'b1;
        state_next    = LOAD_WB;
      end
      LOAD_WB: begin
        regwen_next = 1'b1;
        wbsel       = WB_MDR;
        state_next  = FETCH;
      end
      MEM_WRITE: begin
        memwrite_next = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        alusel = ALU_SUB;
        if ((funct3 == F3_BEQ && zero) || (funct3 == F3_BNE && !zero)) begin
          pcwrite_next = 1'b1;
          pcsourse     = PC_ALU;
        end
        state_next = FETCH;
      end
      JAL: begin
        regwen_next  = 1'b1;
        wbsel        = WB_PC;
        pcwrite_next = 1'b1;
        pcsourse     = PC_ALU;
        state_next   = FETCH;
      end
      TRAP: state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Reset is asynchronous, so the enables are masked combinationally as well.
  assign pcwrite  = pcwrite_next  & ~rst;
  assign pccen    = pccen_next    & ~rst;
  assign irwrite  = irwrite_next  & ~rst;
  assign regwen   = regwen_next   & ~rst;
  assign mdrwrite = mdrwrite_next & ~rst;
  assign memwrite = memwrite_next & ~rst;
  assign illegal  = illegal_reg;

endmodule

// File: tb/tb_rv_ctl.sv
// Scoreboard bench for rv_ctl: per-cycle expected control words are queued
// when an instruction is applied and compared as the FSM walks through it.

module tb_rv_ctl;
  import rv_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        pcsourse, pcwrite, pccen, irwrite, regwen, asel, bsel;
  logic        mdrwrite, memwrite, illegal;
  logic [1:0]  wbsel, immsel;
  logic [3:0]  alusel;

  rv_ctl #(.DPWIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
    .wbsel(wbsel), .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel),
    .alusel(alusel), .mdrwrite(mdrwrite), .memwrite(memwrite), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcsourse;
    logic       pcwrite;
    logic       pccen;
    logic       irwrite;
    logic [1:0] wbsel;
    logic       regwen;
    logic [1:0] immsel;
    logic       asel;
    logic       bsel;
    logic [3:0] alusel;
    logic       mdrwrite;
    logic       memwrite;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string tag;
    ctl_t  c;
  } exp_t;

  typedef enum int { K_R, K_I, K_LW, K_SW, K_BR, K_JAL } kind_t;

  ctl_t obs;
  assign obs = {pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel,
                asel, bsel, alusel, mdrwrite, memwrite, illegal};

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%05h expected=%05h", tag, got, exp);
    end
  endtask

  function automatic ctl_t dflt();
    ctl_t c;
    c          = '0;
    c.pcsourse = PC_PLUS4;
    c.wbsel    = WB_ALUOUT;
    c.immsel   = IMM_L;
    c.asel     = ALUA_REG;
    c.bsel     = ALUB_REG;
    c.alusel   = ALU_ADD;
    return c;
  endfunction

  task automatic push(input string tag, input ctl_t c);
    exp_t e;
    e.tag = tag;
    e.c   = c;
    sb.push_back(e);
  endtask

  task automatic push_fetch_decode(input string name, input logic is_jal);
    ctl_t c;
    c = dflt();
    c.irwrite = 1'b1; c.pccen = 1'b1; c.pcwrite = 1'b1;
    push({name, " fetch"}, c);
    c = dflt();
    c.asel = ALUA_PCC; c.bsel = ALUB_IMM;
    c.immsel = is_jal ? IMM_J : IMM_B;
    push({name, " decode"}, c);
  endtask

  // Pops one expectation per cycle; each wait is a single clock, so it always ends.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check(e.tag, obs, e.c);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input string name, input logic [31:0] ins, input kind_t kind,
                          input logic [3:0] alu, input logic z, input logic taken);
    ctl_t c;
    int   n;
    instr = ins;
    zero  = z;
    push_fetch_decode(name, kind == K_JAL);
    case (kind)
      K_R: begin
        c = dflt(); c.alusel = alu; push({name, " exec"}, c);
        c = dflt(); c.regwen = 1'b1; push({name, " wb"}, c);
      end
      K_I: begin
        c = dflt(); c.bsel = ALUB_IMM; c.alusel = alu; push({name, " exec"}, c);
        c = dflt(); c.regwen = 1'b1; push({name, " wb"}, c);
      end
      K_LW: begin
        c = dflt(); c.bsel = ALUB_IMM; push({name, " addr"}, c);
        c = dflt(); c.mdrwrite = 1'b1; push({name, " read"}, c);
        c = dflt(); c.regwen = 1'b1; c.wbsel = WB_MDR; push({name, " wb"}, c);
      end
      K_SW: begin
        c = dflt(); c.bsel = ALUB_IMM; c.immsel = IMM_S; push({name, " addr"}, c);
        c = dflt(); c.memwrite = 1'b1; push({name, " write"}, c);
      end
      K_BR: begin
        c = dflt(); c.alusel = ALU_SUB;
        if (taken) begin c.pcwrite = 1'b1; c.pcsourse = PC_ALU; end
        push({name, " branch"}, c);
      end
      default: begin
        c = dflt(); c.regwen = 1'b1; c.wbsel = WB_PC; c.pcwrite = 1'b1;
        c.pcsourse = PC_ALU; push({name, " jal"}, c);
      end
    endcase
    n = sb.size();
    drain();
    $display("instr %-8s %08h zero=%0b cycles=%0d", name, ins, z, n);
  endtask

  initial begin
    ctl_t c;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset hold", obs, dflt());
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_instr("add",  32'h002081B3, K_R,  ALU_ADD, 1'b0, 1'b0);
    do_instr("sub",  32'h402081B3, K_R,  ALU_SUB, 1'b0, 1'b0);
    do_instr("xor",  32'h0020C1B3, K_R,  ALU_XOR, 1'b0, 1'b0);
    do_instr("srl",  32'h0020D1B3, K_R,  ALU_SRL, 1'b0, 1'b0);
    do_instr("addi", 32'hFFF08193, K_I,  ALU_ADD, 1'b0, 1'b0);
    do_instr("srai", 32'h4040D193, K_I,  ALU_SRA, 1'b0, 1'b0);
    do_instr("andi", 32'h0FF0F193, K_I,  ALU_AND, 1'b0, 1'b0);
    do_instr("lw",   32'h0080A283, K_LW, ALU_ADD, 1'b0, 1'b0);
    do_instr("sw",   32'h0050A423, K_SW, ALU_ADD, 1'b0, 1'b0);
    do_instr("beq_t", 32'h00208463, K_BR, ALU_SUB, 1'b1, 1'b1);
    do_instr("beq_n", 32'h00208463, K_BR, ALU_SUB, 1'b0, 1'b0);
    do_instr("bne_n", 32'h00209463, K_BR, ALU_SUB, 1'b1, 1'b0);
    do_instr("bne_t", 32'h00209463, K_BR, ALU_SUB, 1'b0, 1'b1);
    do_instr("jal",  32'h010000EF, K_JAL, ALU_ADD, 1'b0, 1'b0);
    do_instr("add2", 32'h002081B3, K_R,  ALU_ADD, 1'b0, 1'b0);

    // Reset abandons a load while it sits in the memory-read cycle.
    instr = 32'h0080A283;
    zero  = 1'b0;
    push_fetch_decode("lwrst", 1'b0);
    c = dflt(); c.bsel = ALUB_IMM; push("lwrst addr", c);
    drain();
    @(negedge clk);
    c = dflt(); c.mdrwrite = 1'b1;
    check("lwrst read", obs, c);
    #1 rst = 1'b1;
    #1 check("lwrst in reset", obs, dflt());
    @(posedge clk);
    #1 rst = 1'b0;
    $display("instr %-8s %08h reset during read", "lwrst", 32'h0080A283);
    do_instr("after_rst", 32'h002081B3, K_R, ALU_ADD, 1'b0, 1'b0);

    // Illegal opcode: trap and hold with no enables.
    instr = 32'h00000000;
    push_fetch_decode("trap", 1'b0);
    for (int i = 0; i < 20; i++) begin
      c = dflt(); c.illegal = 1'b1;
      push($sformatf("trap hold%0d", i), c);
    end
    drain();
    $display("instr %-8s %08h trapped", "illegal", 32'h00000000);
    rst = 1'b1;
    #1 check("trap reset", obs, dflt());
    @(posedge clk);
    #1 rst = 1'b0;
    do_instr("post_trap", 32'h0050A423, K_SW, ALU_ADD, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
